// File: rtl/challenge_checker.sv
// Challenge tracker: predicts the remote scrambler sequence, flags match/mismatch and lock.
// Optional saturating mismatch counter on err_cnt when CHALLENGE_CHECKER_ERR_CNT_EN is defined.
module challenge_checker #(
   parameter int unsigned LOCK_N = 4,
   parameter bit          RESYNC = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] seed,
   input  logic       load,
   input  logic       in_valid,
   input  logic [7:0] in_challenge,
   output logic       in_ready,
   output logic [7:0] expected,
   output logic       match,
   output logic       mismatch,
   output logic       locked,
   output logic       degenerate
`ifdef CHALLENGE_CHECKER_ERR_CNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

   function automatic logic [7:0] step(input logic [7:0] c);
      logic nb;
      nb = c[0] ^ c[1] ^ c[2] ^ c[3] ^ c[7];
      return c ^ {nb, c[7:1]};
   endfunction

   state_e     state_q, state_d;
   logic [7:0] expected_q, expected_d;
   logic [3:0] run_q, run_d;
   logic [3:0] run_inc_s;
   logic       match_q, match_d;
   logic       mismatch_q, mismatch_d;
   logic       locked_q, locked_d;
   logic       in_ready_q, in_ready_d;
   logic       accept_s;

   assign accept_s  = in_valid & in_ready_q & ~load;
   assign run_inc_s = run_q + 4'd1;

   // Next-state: load dominates, then an accepted beat, otherwise everything holds.
   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      run_d      = run_q;
      match_d    = 1'b0;
      mismatch_d = 1'b0;
      if (load) begin
         expected_d = step(seed);
         run_d      = 4'd0;
         state_d    = ST_HUNT;
      end else if (accept_s) begin
         if (in_challenge == expected_q) begin
            match_d    = 1'b1;
            expected_d = step(expected_q);
            case (state_q)
               ST_HUNT: begin
                  run_d = run_inc_s;
                  if (run_inc_s == LOCK_RUN) begin
                     state_d = ST_LOCKED;
                  end else begin
                     state_d = ST_HUNT;
                  end
               end
               ST_LOCKED: state_d = ST_LOCKED;
               default:   state_d = state_q;
            endcase
         end else begin
            mismatch_d = 1'b1;
            run_d      = 4'd0;
            state_d    = ST_HUNT;
            if (RESYNC) begin
               expected_d = step(in_challenge);
            end else begin
               expected_d = step(expected_q);
            end
         end
      end else begin
         state_d = state_q;
      end
      locked_d   = (state_d == ST_LOCKED);
      in_ready_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         expected_q <= 8'h00;
         run_q      <= 4'd0;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         locked_q   <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         run_q      <= run_d;
         match_q    <= match_d;
         mismatch_q <= mismatch_d;
         locked_q   <= locked_d;
         in_ready_q <= in_ready_d;
      end
   end

`ifdef CHALLENGE_CHECKER_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Mismatch counter sticks at 0xFF until the next load.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (load) begin
         err_cnt_d = 8'h00;
      end else if (mismatch_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'h01;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 8'h00;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

   assign in_ready   = in_ready_q;
   assign expected   = expected_q;
   assign match      = match_q;
   assign mismatch   = mismatch_q;
   assign locked     = locked_q;
   assign degenerate = (expected_q == 8'h00);

endmodule

// File: tb/tb_challenge_checker.sv
// Directed bench for challenge_checker: vector table plus reset, free-running and counter sequences.
module tb_challenge_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] seed;
   logic       load;
   logic       in_valid;
   logic [7:0] in_challenge;

   logic       a_ready, a_match, a_mismatch, a_locked, a_degen;
   logic [7:0] a_expected;
   logic       b_ready, b_match, b_mismatch, b_locked, b_degen;
   logic [7:0] b_expected;
`ifdef CHALLENGE_CHECKER_ERR_CNT_EN
   logic [7:0] a_err_cnt, b_err_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   challenge_checker #(.LOCK_N(4), .RESYNC(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .seed(seed), .load(load),
      .in_valid(in_valid), .in_challenge(in_challenge),
      .in_ready(a_ready), .expected(a_expected), .match(a_match),
      .mismatch(a_mismatch), .locked(a_locked), .degenerate(a_degen)
`ifdef CHALLENGE_CHECKER_ERR_CNT_EN
      , .err_cnt(a_err_cnt)
`endif
   );

   challenge_checker #(.LOCK_N(1), .RESYNC(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .seed(seed), .load(load),
      .in_valid(in_valid), .in_challenge(in_challenge),
      .in_ready(b_ready), .expected(b_expected), .match(b_match),
      .mismatch(b_mismatch), .locked(b_locked), .degenerate(b_degen)
`ifdef CHALLENGE_CHECKER_ERR_CNT_EN
      , .err_cnt(b_err_cnt)
`endif
   );

   typedef struct {
      logic       ld;
      logic [7:0] sd;
      logic       vl;
      logic [7:0] ch;
      logic [7:0] e_exp;
      logic       e_m;
      logic       e_mm;
      logic       e_lk;
      logic       e_rdy;
      logic       e_dg;
   } vec_t;

   vec_t tbl [26];

   function automatic logic [7:0] ref_step(input logic [7:0] c);
      logic [7:0] r;
      r      = c >> 1;
      r[7]   = c[0] ^ c[1] ^ c[2] ^ c[3] ^ c[7];
      return c ^ r;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [7:0] sd, input logic vl, input logic [7:0] ch);
      load         = ld;
      seed         = sd;
      in_valid     = vl;
      in_challenge = ch;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [7:0] e, input logic m, input logic mm,
                        input logic lk, input logic rdy, input logic dg);
      chk({tag, ".expected"}, a_expected, e);
      chk({tag, ".match"}, {7'd0, a_match}, {7'd0, m});
      chk({tag, ".mismatch"}, {7'd0, a_mismatch}, {7'd0, mm});
      chk({tag, ".locked"}, {7'd0, a_locked}, {7'd0, lk});
      chk({tag, ".in_ready"}, {7'd0, a_ready}, {7'd0, rdy});
      chk({tag, ".degenerate"}, {7'd0, a_degen}, {7'd0, dg});
   endtask

   initial begin
      //          ld    seed   vl    chal   expected m     mm    lk    rdy   dg
      tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 8'h81, 8'hC1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 8'hC1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h55, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'hA1, 8'hF1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'hF1, 8'h89, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h89, 8'h4D, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 8'h01, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h81, 8'hC1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b1, 8'hC1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b1, 8'hA1, 8'hF1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 1'b1, 8'h81, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 8'hC1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 8'h00, 1'b1, 8'hA1, 8'hF1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 8'h00, 1'b1, 8'hF1, 8'h89, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 8'h00, 1'b1, 8'h89, 8'h4D, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[20] = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[21] = '{1'b0, 8'h00, 1'b1, 8'hC1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[22] = '{1'b0, 8'h00, 1'b1, 8'hA1, 8'hF1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[23] = '{1'b1, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[24] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[25] = '{1'b1, 8'h81, 1'b0, 8'h00, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      rst_n = 1'b0; seed = 8'h00; load = 1'b0; in_valid = 1'b0; in_challenge = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_a("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].ld, tbl[i].sd, tbl[i].vl, tbl[i].ch);
         chk_a($sformatf("vec%0d", i), tbl[i].e_exp, tbl[i].e_m, tbl[i].e_mm,
               tbl[i].e_lk, tbl[i].e_rdy, tbl[i].e_dg);
      end

      // Free-running tracker with single-match lock.
      drive(1'b1, 8'h01, 1'b0, 8'h00);
      chk("b.load.expected", b_expected, 8'h81);
      drive(1'b0, 8'h00, 1'b1, 8'h81);
      chk("b.m1.match", {7'd0, b_match}, 8'h01);
      chk("b.m1.locked", {7'd0, b_locked}, 8'h01);
      chk("b.m1.expected", b_expected, 8'hC1);
      drive(1'b0, 8'h00, 1'b1, 8'h00);
      chk("b.mm.mismatch", {7'd0, b_mismatch}, 8'h01);
      chk("b.mm.locked", {7'd0, b_locked}, 8'h00);
      chk("b.mm.expected", b_expected, 8'hA1);
      drive(1'b0, 8'h00, 1'b1, 8'hA1);
      chk("b.m2.match", {7'd0, b_match}, 8'h01);
      chk("b.m2.locked", {7'd0, b_locked}, 8'h01);
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      chk("b.gap.match", {7'd0, b_match}, 8'h00);
      chk("b.gap.locked", {7'd0, b_locked}, 8'h01);
      chk("b.gap.expected", b_expected, 8'hF1);

      // Asynchronous reset landing on an accepted beat.
      drive(1'b1, 8'h01, 1'b0, 8'h00);
      drive(1'b0, 8'h00, 1'b1, 8'h81);
      chk("pre_rst.match", {7'd0, a_match}, 8'h01);
      in_challenge = 8'hC1;
      #2 rst_n = 1'b0;
      #1;
      chk_a("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk_a("rst_edge", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      drive(1'b0, 8'h00, 1'b1, 8'h81);
      chk_a("post_rst_beat", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h01, 1'b0, 8'h00);
      chk_a("post_rst_load", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef CHALLENGE_CHECKER_ERR_CNT_EN
      begin
         logic [7:0] e;
         logic [7:0] beat;
         e = 8'h81;
         for (int i = 0; i < 300; i++) begin
            beat = e ^ 8'h01;
            drive(1'b0, 8'h00, 1'b1, beat);
            e = ref_step(beat);
            if (i == 0)   chk("err_cnt.first", a_err_cnt, 8'h01);
            if (i == 253) chk("err_cnt.254", a_err_cnt, 8'hFE);
         end
         chk("err_cnt.sat", a_err_cnt, 8'hFF);
         chk("err_cnt.sat.expected", a_expected, e);
         drive(1'b1, 8'h01, 1'b0, 8'h00);
         chk("err_cnt.load", a_err_cnt, 8'h00);
         chk("err_cnt.b.load", b_err_cnt, 8'h00);
      end
`else
      chk("ref_step.chain", ref_step(ref_step(8'h01)), a_expected ^ 8'h40);
`endif

      load = 1'b0; in_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
